// File: rtl/regfile_writeback_arbiter.sv
// regfile_writeback_arbiter
//   Drives the register file write port by merging two writeback sources.
//   The single-cycle ALU pipe always wins. Long-latency (load/mul-div)
//   responses wait in a small FIFO and drain when the ALU is idle. A 32-bit
//   scoreboard marks destinations that still have a long-latency write in
//   flight, so issue logic can stall on RAW/WAW hazards.
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   alu_valid/alu_rd/alu_data     ALU writeback, no backpressure
//   issue_valid/issue_rd          long-latency issue request
//   issue_ready                   issue accepted when valid && ready
//   lsu_valid/lsu_rd/lsu_data     long-latency response
//   lsu_ready                     response FIFO not full
//   rs1/rs2, rs1_busy/rs2_busy    combinational scoreboard queries
//   busy_mask                     full scoreboard vector
//   rd/rd_din/write_enable        registered register-file write port
module regfile_writeback_arbiter #(
  parameter int FIFO_DEPTH      = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic        issue_ready,
  input  logic        lsu_valid,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  output logic        lsu_ready,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic [31:0] busy_mask,
  output logic [4:0]  rd,
  output logic [31:0] rd_din,
  output logic        write_enable
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [OW-1:0] MAX_OUT  = OW'(MAX_OUTSTANDING);
  localparam logic [OW-1:0] OUT_ONE  = OW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [4:0]    fifo_rd   [FIFO_DEPTH];
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic [OW-1:0] outstanding;
  logic [31:0]   busy;
  logic [31:0]   busy_next;

  logic          issue_fire;
  logic          push;
  logic          pop;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;

  assign issue_ready = !reset && !busy[issue_rd] && (outstanding < MAX_OUT);
  assign lsu_ready   = !reset && (fifo_cnt != FULL_CNT);

  assign issue_fire  = issue_valid && issue_ready;
  assign push        = lsu_valid && lsu_ready;
  // The FIFO only drains in cycles the ALU leaves the write port free.
  assign pop         = !alu_valid && (fifo_cnt != '0);

  assign head_rd     = fifo_rd[rd_ptr];
  assign head_data   = fifo_data[rd_ptr];

  assign busy_mask   = busy;
  assign rs1_busy    = busy[rs1];
  assign rs2_busy    = busy[rs2];

  // Set and clear never hit the same bit: issue_ready is low while it is set.
  // x0 is never tracked.
  always_comb begin
    busy_next = busy;
    if (pop)        busy_next[head_rd]  = 1'b0;
    if (issue_fire) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Storage carries no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= lsu_rd;
      fifo_data[wr_ptr] <= lsu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd           <= '0;
      rd_din       <= '0;
      write_enable <= 1'b0;
      busy         <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
      outstanding  <= '0;
    end else begin
      write_enable <= 1'b0;
      if (alu_valid) begin
        rd           <= alu_rd;
        rd_din       <= alu_data;
        write_enable <= (alu_rd != 5'd0);
      end else if (pop) begin
        rd           <= head_rd;
        rd_din       <= head_data;
        write_enable <= (head_rd != 5'd0);
      end

      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;

      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
        2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
        default: fifo_cnt <= fifo_cnt;
      endcase

      case ({issue_fire, pop})
        2'b10:   outstanding <= outstanding + OUT_ONE;
        2'b01:   outstanding <= outstanding - OUT_ONE;
        default: outstanding <= outstanding;
      endcase

      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// tb_regfile_writeback_arbiter
//   Directed bench. Expected register-file writes are queued as stimulus is
//   issued; a negedge monitor pops and compares every asserted write_enable.
//   Scoreboard, ready and timing points are checked inline.
module tb_regfile_writeback_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic [31:0] busy_mask;
  logic [4:0]  rd;
  logic [31:0] rd_din;
  logic        write_enable;

  int tests = 0;
  int fails = 0;

  logic [36:0] sb[$];
  logic [36:0] mon_exp;
  int          tb_outst = 0;

  regfile_writeback_arbiter #(.FIFO_DEPTH(2), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .lsu_ready(lsu_ready),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .busy_mask(busy_mask),
    .rd(rd), .rd_din(rd_din), .write_enable(write_enable)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
    sb.push_back({r, d});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Write monitor: every register-file write must match the next expected one.
  always @(negedge clk) begin
    if (write_enable === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL wb_unexpected: got rd=%0d data=%h, expected no write", rd, rd_din);
      end else begin
        mon_exp = sb.pop_front();
        if ({rd, rd_din} !== mon_exp) begin
          fails++;
          $display("FAIL wb_data: got rd=%0d data=%h, expected rd=%0d data=%h",
                   rd, rd_din, mon_exp[36:32], mon_exp[31:0]);
        end
      end
    end
  end

  // Protocol rules the design relies on the environment to honour.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      tb_outst = 0;
    end else begin
      if (alu_valid && alu_rd != 5'd0 && busy_mask[alu_rd])
        $error("protocol: ALU write to busy register x%0d", alu_rd);
      if (issue_valid && issue_ready) tb_outst++;
      if (lsu_valid && lsu_ready) begin
        if (tb_outst == 0) $error("protocol: response without outstanding issue");
        else tb_outst--;
      end
    end
  end

  initial begin
    reset = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    issue_valid = 1'b0; issue_rd = '0; lsu_valid = 1'b0; lsu_rd = '0;
    lsu_data = '0; rs1 = '0; rs2 = '0;

    // Reset state
    tick(); tick(); tick();
    @(negedge clk);
    check("rst_we", 32'(write_enable), 32'd0);
    check("rst_rd", 32'(rd), 32'd0);
    check("rst_din", rd_din, 32'd0);
    check("rst_busy", busy_mask, 32'd0);
    check("rst_issue_ready", 32'(issue_ready), 32'd0);
    check("rst_lsu_ready", 32'(lsu_ready), 32'd0);
    tick(); reset = 1'b0;
    @(negedge clk);
    check("post_rst_issue_ready", 32'(issue_ready), 32'd1);
    check("post_rst_lsu_ready", 32'(lsu_ready), 32'd1);

    // Single ALU write, one-cycle latency
    tick(); alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    expect_wr(5'd5, 32'hDEADBEEF);
    tick(); alu_valid = 1'b0;
    @(negedge clk);
    check("alu_we", 32'(write_enable), 32'd1);
    check("alu_rd", 32'(rd), 32'd5);
    check("alu_din", rd_din, 32'hDEADBEEF);
    tick();
    @(negedge clk);
    check("alu_we_drop", 32'(write_enable), 32'd0);
    check("alu_rd_hold", 32'(rd), 32'd5);

    // Long-latency round trip for x10
    tick(); issue_valid = 1'b1; issue_rd = 5'd10; rs1 = 5'd10;
    @(negedge clk);
    check("x10_issue_ready", 32'(issue_ready), 32'd1);
    tick(); issue_valid = 1'b0;
    @(negedge clk);
    check("x10_busy_mask", busy_mask, 32'h400);
    check("x10_rs1_busy", 32'(rs1_busy), 32'd1);
    tick(); lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 32'h1234;
    expect_wr(5'd10, 32'h1234);
    @(negedge clk);
    check("x10_lsu_ready", 32'(lsu_ready), 32'd1);
    tick(); lsu_valid = 1'b0;
    @(negedge clk);
    check("x10_we_c1", 32'(write_enable), 32'd0);
    check("x10_busy_c1", busy_mask, 32'h400);
    tick();
    @(negedge clk);
    check("x10_we_c2", 32'(write_enable), 32'd1);
    check("x10_rd_c2", 32'(rd), 32'd10);
    check("x10_busy_c2", busy_mask, 32'd0);
    check("x10_rs1_busy_c2", 32'(rs1_busy), 32'd0);

    // ALU priority over a queued x3 response
    tick(); issue_valid = 1'b1; issue_rd = 5'd3;
    tick(); issue_valid = 1'b0;
    tick(); lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h33;
    tick(); lsu_valid = 1'b0; alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h70;
    expect_wr(5'd7, 32'h70);
    tick(); alu_data = 32'h71; expect_wr(5'd7, 32'h71);
    tick(); alu_data = 32'h72; expect_wr(5'd7, 32'h72); expect_wr(5'd3, 32'h33);
    tick(); alu_valid = 1'b0; rs1 = 5'd3; rs2 = 5'd3;
    @(negedge clk);
    check("pri_we_alu3", 32'(write_enable), 32'd1);
    check("pri_rd_alu3", 32'(rd), 32'd7);
    check("pri_busy_held", busy_mask, 32'h8);
    check("pri_rs1_busy", 32'(rs1_busy), 32'd1);
    tick();
    @(negedge clk);
    check("pri_we_x3", 32'(write_enable), 32'd1);
    check("pri_rd_x3", 32'(rd), 32'd3);
    check("pri_busy_clear", busy_mask, 32'd0);
    check("pri_rs2_busy", 32'(rs2_busy), 32'd0);

    // Hazard stall on x8
    tick(); issue_valid = 1'b1; issue_rd = 5'd8;
    @(negedge clk);
    check("haz_first_ready", 32'(issue_ready), 32'd1);
    tick(); lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_data = 32'h88;
    expect_wr(5'd8, 32'h88);
    @(negedge clk);
    check("haz_stall_b0", 32'(issue_ready), 32'd0);
    tick(); lsu_valid = 1'b0;
    @(negedge clk);
    check("haz_stall_b1", 32'(issue_ready), 32'd0);
    tick(); issue_valid = 1'b0;
    @(negedge clk);
    check("haz_write_x8", 32'(rd), 32'd8);
    check("haz_release", 32'(issue_ready), 32'd1);

    // Outstanding limit
    tick(); issue_valid = 1'b1; issue_rd = 5'd1;
    @(negedge clk);
    check("lim_ready_x1", 32'(issue_ready), 32'd1);
    tick(); issue_rd = 5'd2;
    @(negedge clk);
    check("lim_ready_x2", 32'(issue_ready), 32'd1);
    tick(); issue_rd = 5'd4;
    @(negedge clk);
    check("lim_block_x4", 32'(issue_ready), 32'd0);
    check("lim_busy_mask", busy_mask, 32'h6);
    tick(); issue_valid = 1'b0; lsu_valid = 1'b1; lsu_rd = 5'd1; lsu_data = 32'h11;
    expect_wr(5'd1, 32'h11);
    tick(); lsu_rd = 5'd2; lsu_data = 32'h22;
    expect_wr(5'd2, 32'h22);
    tick(); lsu_valid = 1'b0;
    tick(); tick(); tick();
    @(negedge clk);
    check("lim_busy_drained", busy_mask, 32'd0);

    // x0 writes are suppressed but still retire
    tick(); alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h99;
    tick(); alu_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd0;
    @(negedge clk);
    check("x0_issue_ready", 32'(issue_ready), 32'd1);
    tick(); issue_valid = 1'b0; lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h55;
    @(negedge clk);
    check("x0_busy_after_issue", busy_mask, 32'd0);
    tick(); lsu_valid = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("x0_busy", busy_mask, 32'd0);
    check("x0_we", 32'(write_enable), 32'd0);

    // Two issues must both be accepted: the x0 op left nothing outstanding
    tick(); issue_valid = 1'b1; issue_rd = 5'd11;
    @(negedge clk);
    check("rr_ready_x11", 32'(issue_ready), 32'd1);
    tick(); issue_rd = 5'd12;
    @(negedge clk);
    check("rr_ready_x12", 32'(issue_ready), 32'd1);
    // Fill the FIFO behind a busy ALU, then reset mid-operation
    tick(); issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'hA0;
    lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_data = 32'hB1;
    expect_wr(5'd20, 32'hA0);
    tick(); alu_data = 32'hA1; lsu_rd = 5'd12; lsu_data = 32'hB2;
    expect_wr(5'd20, 32'hA1);
    @(negedge clk);
    check("rr_lsu_ready_one", 32'(lsu_ready), 32'd1);
    tick(); alu_data = 32'hA2; lsu_valid = 1'b0;
    expect_wr(5'd20, 32'hA2);
    @(negedge clk);
    check("rr_lsu_ready_full", 32'(lsu_ready), 32'd0);
    check("rr_busy_before", busy_mask, 32'h1800);
    tick(); reset = 1'b1; alu_valid = 1'b0;
    tick(); reset = 1'b0; issue_rd = 5'd11;
    @(negedge clk);
    check("rr_busy_after", busy_mask, 32'd0);
    check("rr_issue_ready", 32'(issue_ready), 32'd1);
    check("rr_lsu_ready", 32'(lsu_ready), 32'd1);
    check("rr_we", 32'(write_enable), 32'd0);
    tick(); tick(); tick(); tick();

    @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_writeback_arbiter.md
Name: regfile_writeback_arbiter

Overview:
- Drives the register file write port (rd, rd_din, write_enable). It is the writer end of that interface.
- Merges two writeback sources. The single-cycle ALU pipe has absolute priority. Long-latency load/mul-div responses are buffered in a small FIFO.
- Keeps a 32-bit scoreboard of destination registers with writes still pending, so issue logic can stall on RAW/WAW hazards.

Parameters:
- FIFO_DEPTH, 2: entries in the long-latency response FIFO; power of two, at least 2.
- MAX_OUTSTANDING, 2: issued-but-not-yet-written long-latency ops allowed; at most FIFO_DEPTH.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high.
- alu_valid  input  1  ALU writeback this cycle; no backpressure.
- alu_rd  input  5  ALU destination register.
- alu_data  input  32  ALU result.
- issue_valid  input  1  long-latency op issue request.
- issue_rd  input  5  destination of the issued op.
- issue_ready  output  1  issue accepted when issue_valid && issue_ready.
- lsu_valid  input  1  long-latency response valid.
- lsu_rd  input  5  response destination.
- lsu_data  input  32  response data.
- lsu_ready  output  1  FIFO not full.
- rs1  input  5  scoreboard query port 1.
- rs2  input  5  scoreboard query port 2.
- rs1_busy  output  1  busy[rs1], combinational.
- rs2_busy  output  1  busy[rs2], combinational.
- busy_mask  output  32  full scoreboard vector.
- rd  output  5  register file destination, registered.
- rd_din  output  32  register file write data, registered.
- write_enable  output  1  register file write strobe, registered.

Behaviour:
- Reset (sync, high):
  - rd=0, rd_din=0, write_enable=0.
  - busy_mask=0, FIFO empty, outstanding count=0.
  - While reset is high, issue_ready=0 and lsu_ready=0.
  - Reset asserted mid-operation discards all FIFO contents and pending busy bits; no write occurs on the reset edge.
- issue_ready (combinational) = !reset && !busy[issue_rd] && (outstanding < MAX_OUTSTANDING).
  - issue_rd=0 is always ready if the count allows. It increments outstanding but never sets busy[0].
- Issue handshake: set busy[issue_rd] (if non-zero) and increment outstanding at the edge.
- lsu_ready = !reset && FIFO not full.
- Response handshake: push {lsu_rd, lsu_data} at the edge. There is no bypass, so the entry is visible at the head the next cycle.
- Write select, each cycle:
  - If alu_valid: register rd=alu_rd, rd_din=alu_data, write_enable=(alu_rd!=0). FIFO holds.
  - Else if FIFO non-empty: pop head; register rd/rd_din from it, write_enable=(head_rd!=0); clear busy[head_rd]; decrement outstanding.
  - Else: write_enable=0; rd and rd_din hold their previous values.
- Latency:
  - ALU input to write_enable: 1 cycle.
  - Response handshake to write_enable: minimum 2 cycles, unbounded while alu_valid stays high.
- Simultaneous events:
  - Issue and pop in the same cycle: outstanding stays unchanged.
  - Set and clear of the same busy bit cannot coincide because issue_ready is low while that bit is set.
  - Push and pop in the same cycle are both performed.
- busy bits clear on the pop edge. rs*_busy therefore drops in the same cycle write_enable rises, and the register file holds the value one edge later. Consumers needing the value earlier must forward from rd/rd_din.
- Protocol rules, checked by bench assertions, not handled in RTL:
  - alu_valid with busy[alu_rd]=1 is illegal (WAW); the pipeline must stall.
  - lsu_valid without a matching outstanding issue is illegal.
- FIFO pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished by an occupancy counter.

Test Plan:
- Reset, then alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for one cycle -> next cycle rd=5, rd_din=0xDEADBEEF, write_enable=1; following cycle write_enable=0.
- Issue rd=10 -> busy_mask=0x400; response lsu_rd=10, lsu_data=0x1234 -> write_enable=1 with rd=10 two cycles after the handshake; busy_mask=0 from that cycle.
- ALU priority: response for rd=3 queued, alu_valid held 3 cycles (rd=7) -> three ALU writes to x7, then the x3 write in the 4th cycle; busy[3] is held until then.
- Hazard stall: issue rd=8 accepted, then issue_valid with rd=8 -> issue_ready=0 until the x8 write; with two outstanding ops (rd=1, rd=2) issue_ready=0 for rd=4.
- x0 handling: alu_rd=0 and lsu_rd=0 responses -> write_enable never asserts; outstanding still decrements; busy_mask stays 0.
- Mid-operation reset with 2 entries queued -> busy_mask=0, no writes after reset, issue_ready=1 on the first non-reset cycle.
